// File: rtl/seg_scan_driver_if.sv
// rtl/seg_scan_driver_if.sv - byte write handshake into the 7-segment scan driver
interface seg_scan_driver_if;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - multiplexed hex 7-segment scan driver; optional SEG_LEADING_ZERO_BLANK_EN
module seg_scan_driver #(
  parameter int CLK_DIV   = 100000,
  parameter int BLANK_CYC = 16,
  parameter int DIGITS    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  seg_scan_driver_if.slave          wr,
  input  logic                      clear,
  input  logic [DIGITS-1:0]         dp_mask,
  output logic [DIGITS-1:0]         an,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [$clog2(DIGITS)-1:0] digit_idx
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam int DW = $clog2(DIGITS);
  localparam int NB = 4 * DIGITS;

  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYC - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(DIGITS - 1);

  typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

  state_t        state;
  logic [BW-1:0] blank_cnt;
  logic [PW-1:0] presc;
  logic [NB-1:0] disp_buf;
  logic          pend_valid;
  logic [7:0]    pend_data;
  logic          drive_end;
  logic [3:0]    nib;

  // Last cycle of a digit's drive window: the only point where data and index may change.
  assign drive_end = (state == ST_DRIVE) && (presc == PRESC_LAST);

  // One pending byte at most; clear holds off new bytes for the whole time it is asserted.
  assign wr.wr_ready = ~pend_valid & ~clear;

  // Scan FSM: blanking gap, then drive the current digit, then step to the next digit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_BLANK;
      blank_cnt <= '0;
      presc     <= '0;
      digit_idx <= '0;
    end else begin
      case (state)
        ST_BLANK: begin
          if (blank_cnt == BLANK_LAST) begin
            blank_cnt <= '0;
            state     <= ST_DRIVE;
          end else begin
            blank_cnt <= blank_cnt + 1'b1;
          end
        end
        ST_DRIVE: begin
          if (presc == PRESC_LAST) begin
            presc     <= '0;
            state     <= ST_BLANK;
            digit_idx <= (digit_idx == DIGIT_LAST) ? '0 : digit_idx + 1'b1;
          end else begin
            presc <= presc + 1'b1;
          end
        end
        default: state <= ST_BLANK;
      endcase
    end
  end

  // Display buffer and pending byte; a byte is shifted in only at a digit boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_buf   <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
    end else if (clear) begin
      disp_buf   <= '0;
      pend_valid <= 1'b0;
    end else if (drive_end && pend_valid) begin
      disp_buf   <= (disp_buf << 8) | NB'(pend_data);
      pend_valid <= 1'b0;
    end else if (wr.wr_valid && wr.wr_ready) begin
      pend_valid <= 1'b1;
      pend_data  <= wr.wr_data;
    end
  end

  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_seg = 7'h40;
      4'h1: hex_seg = 7'h79;
      4'h2: hex_seg = 7'h24;
      4'h3: hex_seg = 7'h30;
      4'h4: hex_seg = 7'h19;
      4'h5: hex_seg = 7'h12;
      4'h6: hex_seg = 7'h02;
      4'h7: hex_seg = 7'h78;
      4'h8: hex_seg = 7'h00;
      4'h9: hex_seg = 7'h10;
      4'hA: hex_seg = 7'h08;
      4'hB: hex_seg = 7'h03;
      4'hC: hex_seg = 7'h46;
      4'hD: hex_seg = 7'h21;
      4'hE: hex_seg = 7'h06;
      default: hex_seg = 7'h0E;
    endcase
  endfunction

  assign nib = disp_buf[{digit_idx, 2'b00} +: 4];

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] lead_zero;

  // lead_zero[k] is set when digit k and every digit to its left hold zero.
  always_comb begin
    logic run;
    lead_zero = '0;
    run       = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      run          = run & (disp_buf[4*k +: 4] == 4'h0);
      lead_zero[k] = run;
    end
  end
`endif

  // Outputs follow registered state only, so an async reset blanks the display at once.
  always_comb begin
    an  = '1;
    seg = 7'h7F;
    dp  = 1'b1;
    if (state == ST_DRIVE) begin
      an  = ~(DIGITS'(1) << digit_idx);
      seg = hex_seg(nib);
      dp  = ~dp_mask[digit_idx];
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if (lead_zero[digit_idx] && (digit_idx != '0)) seg = 7'h7F;
`endif
    end
  end

endmodule
